// File: rtl/fwft_read_controller.sv
// First-word-fall-through read sequencer for a 1-cycle-latency standard FIFO, with a 2-entry output/skid buffer.
// Optional FWFT_UNDERFLOW_FLAG_EN adds a sticky underflow output for pops made while out_valid=0.
module fwft_read_controller #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  out_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
`ifdef FWFT_UNDERFLOW_FLAG_EN
  output logic                  underflow,
`endif
  output logic [1:0]            buf_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] skid;
  logic                  pop_c;
  logic [2:0]            level_c;

  // Buffer level after this cycle if no new read were issued; pops need out_valid so it never wraps.
  assign pop_c      = out_rd_en & out_valid;
  assign level_c    = 3'(occ) + 3'(inflight) - 3'(pop_c);
  assign fifo_rd_en = ~reset & ~fifo_empty & (level_c <= 3'd1);
  assign buf_count  = occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ       <= EMPTY;
      inflight  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else begin
      inflight  <= fifo_rd_en;
      occ       <= occ_t'(level_c[1:0]);
      out_valid <= (level_c != 3'd0);
      // Route the returning word: straight to the head when the head is free or being popped.
      case (occ)
        EMPTY: begin
          if (inflight) out_data <= fifo_dout;
        end
        ONE: begin
          if (inflight && pop_c)  out_data <= fifo_dout;
          else if (inflight)      skid     <= fifo_dout;
        end
        TWO: begin
          if (pop_c) out_data <= skid;
        end
        default: ;
      endcase
      assert (!(occ == TWO && inflight));
    end
  end

`ifdef FWFT_UNDERFLOW_FLAG_EN
  // Sticky record of any pop attempted against an empty buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (out_rd_en && !out_valid) begin
      underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fwft_read_controller.sv
// Scoreboard bench for fwft_read_controller driving a behavioural 8x16 standard FIFO.
module tb_fwft_read_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_clr;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       out_rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic [1:0] buf_count;
`ifdef FWFT_UNDERFLOW_FLAG_EN
  logic       underflow;
`endif

  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  int         fcount;

  int         checks = 0;
  int         errors = 0;
  int         rd_pulses = 0;
  int         pops = 0;
  int         cyc = 0;
  int         wr_count = 0;
  int         first_pop = -1;
  int         last_pop = -1;
  logic       popped;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  fwft_read_controller #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .out_rd_en  (out_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
`ifdef FWFT_UNDERFLOW_FLAG_EN
    .underflow  (underflow),
`endif
    .buf_count  (buf_count)
  );

  // Behavioural standard_fifo: registered dout one cycle after rd_en.
  assign fifo_empty = (fcount == 0);
  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= 4'd0; rp <= 4'd0; fcount <= 0; fifo_dout <= 8'h00;
    end else begin
      if (wr_en) begin mem[wp] <= wr_data; wp <= wp + 4'd1; end
      if (fifo_rd_en && fcount != 0) begin fifo_dout <= mem[rp]; rp <= rp + 4'd1; end
      fcount <= fcount + (wr_en ? 1 : 0) - ((fifo_rd_en && fcount != 0) ? 1 : 0);
    end
  end

  task automatic cycle(input logic wr, input logic [7:0] wd, input logic rd);
    logic [7:0] exp;
    @(negedge clk);
    cyc++;
    popped = 1'b0;
    if (rd && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_extra: popped 0x%02h with empty scoreboard", out_data);
      end else begin
        exp = sb.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL pop_data: got 0x%02h expected 0x%02h", out_data, exp);
        end
      end
      popped = 1'b1;
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (wr && fcount < 16) begin
      wr_en = 1'b1; wr_data = wd; sb.push_back(wd); wr_count++;
    end else begin
      wr_en = 1'b0;
    end
    out_rd_en = rd;
    #1;
    if (fifo_rd_en) rd_pulses++;
  endtask

  task automatic test_reset();
    reset = 1'b1; fifo_clr = 1'b1; wr_en = 1'b0; wr_data = 8'h00; out_rd_en = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || buf_count !== 2'd0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=0x%02h count=%0d rd_en=%b, expected 0/0x00/0/0",
               out_valid, out_data, buf_count, fifo_rd_en);
    end
`ifdef FWFT_UNDERFLOW_FLAG_EN
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
`endif
    reset = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic test_single();
    int p0;
    p0 = rd_pulses;
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL single_issue: rd_en=%b expected 1", fifo_rd_en); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_t1: valid=%b expected 0", out_valid); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || buf_count !== 2'd1) begin
      errors++;
      $display("FAIL single_t2: valid=%b data=0x%02h count=%0d expected 1/0xa5/1", out_valid, out_data, buf_count);
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (rd_pulses - p0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", rd_pulses - p0); end
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_stream();
    int p0, n;
    p0 = pops; first_pop = -1; last_pop = -1; n = 0;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b1);
    while (sb.size() > 0 && n < 50) begin cycle(1'b0, 8'h00, 1'b1); n++; end
    checks++;
    if (pops - p0 !== 16 || last_pop - first_pop !== 15) begin
      errors++;
      $display("FAIL stream_gapless: pops=%0d span=%0d expected 16/15", pops - p0, last_pop - first_pop);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: valid=%b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int p0, n;
    p0 = rd_pulses; n = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    repeat (6) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (rd_pulses - p0 !== 2) begin errors++; $display("FAIL bp_pulses: got %0d expected 2", rd_pulses - p0); end
    checks++;
    if (buf_count !== 2'd2 || out_data !== 8'h10 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: count=%0d data=0x%02h valid=%b expected 2/0x10/1", buf_count, out_data, out_valid);
    end
    while (sb.size() > 0 && n < 30) begin cycle(1'b0, 8'h00, 1'b1); n++; end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: %0d words left, expected 0", sb.size()); end
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_underflow();
    int p0;
    p0 = rd_pulses;
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || buf_count !== 2'd0 || rd_pulses != p0) begin
      errors++;
      $display("FAIL underflow_nochange: valid=%b count=%0d pulses=%0d expected 0/0/0",
               out_valid, buf_count, rd_pulses - p0);
    end
    cycle(1'b0, 8'h00, 1'b0);
`ifdef FWFT_UNDERFLOW_FLAG_EN
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b expected 1", underflow); end
    test_reset();
    @(negedge clk);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b expected 0", underflow); end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (buf_count !== 2'd2) begin errors++; $display("FAIL mid_full: count=%0d expected 2", buf_count); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL mid_issue: rd_en=%b expected 1", fifo_rd_en); end
    @(negedge clk);
    reset = 1'b1; out_rd_en = 1'b0; wr_en = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rd_en_r0: rd_en=%b expected 0", fifo_rd_en); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || buf_count !== 2'd0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=0x%02h count=%0d rd_en=%b expected 0/0x00/0/0",
               out_valid, out_data, buf_count, fifo_rd_en);
    end
    fifo_clr = 1'b1;
    @(negedge clk);
    reset = 1'b0; fifo_clr = 1'b0;
    sb.delete();
  endtask

  task automatic test_random();
    int p0, w0, n;
    p0 = pops; w0 = wr_count; n = 0;
    while ((wr_count - w0 < 1000 || sb.size() > 0) && n < 20000) begin
      cycle((wr_count - w0 < 1000) && ($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 55));
      n++;
    end
    checks++;
    if (n >= 20000) begin errors++; $display("FAIL random_timeout: %0d words left after %0d cycles", sb.size(), n); end
    checks++;
    if (pops - p0 !== 1000) begin errors++; $display("FAIL random_count: popped %0d expected 1000", pops - p0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
